core_seq_ctrl: RTL and testbench
================================

// Module: core_seq_ctrl
// PURPOSE
//  Sequencer for the attention core: issues the 17-bit inst word one word per clk to run one full pass.
//  Pass order: Q rows into qmem, K rows into kmem, K preload into mac_array, Q streaming (execute),
//   ofifo drain into psum mem, psum readout. Host supplies mem_in data through a valid/ready handshake.
//  Sits between the host/testbench and core; the only block that drives core.inst.
// PARAMETERS
//  QROWS     8  number of Q vectors per pass (1..16); sets the qmem, psum mem and readout count.
//  KROWS     8  number of K vectors per pass (1..16); sets the kmem write and preload count.
//  LOAD_PAD  2  idle cycles after preload before execute (array settle); 0 is legal.
// PORTS
//  clk          in   1   clock, rising edge.
//  reset        in   1   asynchronous, active-low reset.
//  start        in   1   pulse; begins a pass when in IDLE, ignored otherwise.
//  in_valid     in   1   host data word on mem_in valid during Q/K write phases.
//  in_ready     out  1   controller accepts the host word this cycle (high only in QWR/KWR).
//  fifo_valid   in   1   ofifo o_valid from core.
//  inst         out  17  core instruction. Fields:
//                          [16]    ofifo_rd
//                          [15:12] qk address
//                          [11:8]  psum address
//                          [7]     execute
//                          [6]     load
//                          [5:4]   qmem rd/wr
//                          [3:2]   kmem rd/wr
//                          [1:0]   pmem rd/wr
//  out_valid    out  1   psum readout word is valid on core.out this cycle.
//  busy         out  1   high in every state except IDLE.
//  done         out  1   one-cycle pulse on the cycle the FSM returns to IDLE after READ.
// BEHAVIOUR
//  Reset: async to IDLE. inst=0, in_ready=0, out_valid=0, busy=0, done=0, all counters=0.
//   Reset mid-pass aborts the pass immediately; no partial resume.
//  inst, out_valid and done are registered: a field decided in cycle n appears after edge n.
//  States and transitions (cnt = phase counter, cleared on every state entry):
//   IDLE  : inst=0. start -> QWR.
//   QWR   : in_ready=1.
//           in_valid&&in_ready -> qmem_wr=1, qk address=cnt, cnt++.
//           Otherwise inst=0 (stall, no write).
//           Write at cnt=QROWS-1 -> KWR.
//   KWR   : same handshake with kmem_wr. Write at cnt=KROWS-1 -> KLOAD.
//   KLOAD : kmem_rd=1, load=1, qk address=cnt for KROWS consecutive cycles (no stalls).
//           Then -> PAD, or -> EXEC if LOAD_PAD=0.
//   PAD   : inst=0 for LOAD_PAD cycles -> EXEC.
//   EXEC  : qmem_rd=1, execute=1, qk address=cnt for QROWS consecutive cycles -> DRAIN.
//   DRAIN : each cycle with fifo_valid=1 -> ofifo_rd=1, pmem_wr=1, psum address=cnt, cnt++.
//           Cycles with fifo_valid=0 -> inst=0 and wait.
//           After QROWS drains -> READ.
//   READ  : pmem_rd=1, psum address=cnt for QROWS cycles.
//           out_valid=1 one cycle after each pmem_rd (SRAM read latency 1).
//           After last rd -> IDLE with done=1 on the following cycle, coincident with the final out_valid.
//  Invariants:
//   - Never more than one of qmem_wr/kmem_wr/pmem_wr set.
//   - execute and load never both set.
//   - ofifo_rd only when fifo_valid was high in the same cycle.
//  Edges:
//   - start while busy: ignored.
//   - in_valid while not in QWR/KWR: ignored.
//   - in_valid drop mid-phase: stall, address holds.
//   - fifo_valid never asserted: DRAIN waits indefinitely (busy stays 1).
//   - QROWS=16 / KROWS=16: address reaches 4'hF, no wrap into a second pass.
// TESTING
//  1. Reset: assert reset=0 mid-EXEC -> next sample inst=0, busy=0, out_valid=0; start accepted after release.
//  2. Nominal pass (QROWS=KROWS=8, LOAD_PAD=2, in_valid held 1):
//     8 qmem_wr addr 0..7, then 8 kmem_wr, then 8 load cycles, 2 idle, 8 execute, drain, 8 pmem_rd.
//     done exactly once.
//  3. Host stall: drop in_valid for 3 cycles at QWR cnt=4 -> inst=0 for 3 cycles, next write uses addr 4, no gaps or duplicates.
//  4. Drain backpressure: fifo_valid toggles 1,0,1,0 -> ofifo_rd/pmem_wr only on valid cycles, psum address 0..7 contiguous.
//  5. start pulsed during KLOAD and during READ -> ignored; sequence and done count unchanged.
//  6. Corners: LOAD_PAD=0 -> EXEC starts the cycle after the last load. QROWS=16 -> psum address reaches F, then IDLE.

Source files
------------

// File: rtl/core_seq_ctrl.sv
// Attention-core pass sequencer: one 17-bit inst word per clock,
// walking Q/K load, K preload, execute, ofifo drain and psum readout.
`timescale 1ns/1ps
module core_seq_ctrl #(
   parameter int QROWS    = 8,
   parameter int KROWS    = 8,
   parameter int LOAD_PAD = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        fifo_valid,
   output logic [16:0] inst,
   output logic        out_valid,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE, S_QWR, S_KWR, S_KLOAD,
      S_PAD, S_EXEC, S_DRAIN, S_READ
   } state_t;

   localparam logic [7:0] QLAST = 8'(QROWS - 1);
   localparam logic [7:0] KLAST = 8'(KROWS - 1);
   localparam logic [7:0] PLAST =
      (LOAD_PAD > 0) ? 8'(LOAD_PAD - 1) : 8'd0;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [16:0] inst_q, inst_d;
   logic        out_valid_q, out_valid_d;
   logic        done_q, done_d;
   logic [3:0]  addr;

   assign addr      = cnt_q[3:0];
   assign in_ready  = (state_q == S_QWR) || (state_q == S_KWR);
   assign busy      = (state_q != S_IDLE);
   assign inst      = inst_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      inst_d      = '0;
      // psum SRAM answers one cycle after each pmem_rd
      out_valid_d = inst_q[1];
      done_d      = inst_q[1] && (state_q == S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_QWR;
               cnt_d   = '0;
            end
         end
         S_QWR: begin
            if (in_valid) begin
               inst_d[15:12] = addr;
               inst_d[4]     = 1'b1;
               cnt_d         = cnt_q + 8'd1;
               if (cnt_q == QLAST) begin
                  state_d = S_KWR;
                  cnt_d   = '0;
               end
            end
         end
         S_KWR: begin
            if (in_valid) begin
               inst_d[15:12] = addr;
               inst_d[2]     = 1'b1;
               cnt_d         = cnt_q + 8'd1;
               if (cnt_q == KLAST) begin
                  state_d = S_KLOAD;
                  cnt_d   = '0;
               end
            end
         end
         S_KLOAD: begin
            inst_d[15:12] = addr;
            inst_d[6]     = 1'b1;
            inst_d[3]     = 1'b1;
            cnt_d         = cnt_q + 8'd1;
            if (cnt_q == KLAST) begin
               state_d = (LOAD_PAD > 0) ? S_PAD : S_EXEC;
               cnt_d   = '0;
            end
         end
         S_PAD: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == PLAST) begin
               state_d = S_EXEC;
               cnt_d   = '0;
            end
         end
         S_EXEC: begin
            inst_d[15:12] = addr;
            inst_d[7]     = 1'b1;
            inst_d[5]     = 1'b1;
            cnt_d         = cnt_q + 8'd1;
            if (cnt_q == QLAST) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end
         end
         S_DRAIN: begin
            if (fifo_valid) begin
               inst_d[16]   = 1'b1;
               inst_d[11:8] = addr;
               inst_d[0]    = 1'b1;
               cnt_d        = cnt_q + 8'd1;
               if (cnt_q == QLAST) begin
                  state_d = S_READ;
                  cnt_d   = '0;
               end
            end
         end
         S_READ: begin
            inst_d[11:8] = addr;
            inst_d[1]    = 1'b1;
            cnt_d        = cnt_q + 8'd1;
            if (cnt_q == QLAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         inst_q      <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         inst_q      <= inst_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: two configurations driven together,
// per-pass traces checked against pass-level ordering rules.
`timescale 1ns/1ps
module tb_core_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i, in_valid, fifo_valid;
  logic        a_rdy, a_ov, a_busy, a_done;
  logic        b_rdy, b_ov, b_busy, b_done;
  logic [16:0] a_inst, b_inst;
  logic        rec;
  int          n_chk = 0;
  int          n_err = 0;

  typedef struct packed {
    logic [16:0] inst;
    logic ov, dn, bsy, rdy, iv, fv;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];

  core_seq_ctrl #(.QROWS(8), .KROWS(8), .LOAD_PAD(2)) u_a (
    .clk(clk), .reset(reset), .start(start_i),
    .in_valid(in_valid), .in_ready(a_rdy),
    .fifo_valid(fifo_valid), .inst(a_inst),
    .out_valid(a_ov), .busy(a_busy), .done(a_done));

  core_seq_ctrl #(.QROWS(16), .KROWS(16), .LOAD_PAD(0)) u_b (
    .clk(clk), .reset(reset), .start(start_i),
    .in_valid(in_valid), .in_ready(b_rdy),
    .fifo_valid(fifo_valid), .inst(b_inst),
    .out_valid(b_ov), .busy(b_busy), .done(b_done));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rec) begin
      qa.push_back({a_inst, a_ov, a_done, a_busy,
                    a_rdy, in_valid, fifo_valid});
      qb.push_back({b_inst, b_ov, b_done, b_busy,
                    b_rdy, in_valid, fifo_valid});
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ph: 0 qwr 1 kwr 2 load 3 exec 4 drain 5 read
  function automatic logic [16:0] mk(input int ph, input int a);
    logic [16:0] w;
    logic [3:0]  ad;
    w  = '0;
    ad = 4'(a);
    case (ph)
      0: begin w[15:12] = ad; w[4] = 1'b1; end
      1: begin w[15:12] = ad; w[2] = 1'b1; end
      2: begin w[15:12] = ad; w[6] = 1'b1; w[3] = 1'b1; end
      3: begin w[15:12] = ad; w[7] = 1'b1; w[5] = 1'b1; end
      4: begin w[11:8] = ad; w[16] = 1'b1; w[0] = 1'b1; end
      default: begin w[11:8] = ad; w[1] = 1'b1; end
    endcase
    return w;
  endfunction

  task automatic check_trace(input int which);
    ent_t t[$];
    logic [16:0] obs[$];
    logic [16:0] exp[$];
    logic [16:0] w;
    string p;
    int qr, kr, pd, n, m, seqe;
    int lkw, fl, ll, fe, le, ld, fr, lr;
    int hs, fer, inv, ovm, nov, ndn, di, nb, nr;
    if (which == 0) begin
      t = qa; qr = 8; kr = 8; pd = 2; p = "A";
    end else begin
      t = qb; qr = 16; kr = 16; pd = 0; p = "B";
    end
    for (int a = 0; a < qr; a++) exp.push_back(mk(0, a));
    for (int a = 0; a < kr; a++) exp.push_back(mk(1, a));
    for (int a = 0; a < kr; a++) exp.push_back(mk(2, a));
    for (int a = 0; a < qr; a++) exp.push_back(mk(3, a));
    for (int a = 0; a < qr; a++) exp.push_back(mk(4, a));
    for (int a = 0; a < qr; a++) exp.push_back(mk(5, a));
    n = t.size();
    lkw = -1; fl = -1; ll = -1; fe = -1; le = -1;
    ld = -1; fr = -1; lr = -1; di = -1;
    hs = 0; fer = 0; inv = 0; ovm = 0;
    nov = 0; ndn = 0; nb = 0; nr = 0; seqe = 0;
    for (int i = 0; i < n; i++) begin
      w = t[i].inst;
      if (w != '0) obs.push_back(w);
      if (w[2]) lkw = i;
      if (w[6]) begin if (fl < 0) fl = i; ll = i; end
      if (w[7]) begin if (fe < 0) fe = i; le = i; end
      if (w[16]) ld = i;
      if (w[1]) begin if (fr < 0) fr = i; lr = i; end
      if (int'(w[4]) + int'(w[2]) + int'(w[0]) > 1) inv++;
      if (w[7] && w[6]) inv++;
      if (t[i].ov) nov++;
      if (t[i].dn) begin ndn++; di = i; end
      if (t[i].bsy) nb++;
      if (t[i].rdy) nr++;
      if (i > 0) begin
        if ((w[4] | w[2]) != (t[i-1].iv && t[i-1].rdy)) hs++;
        if (w[16] && !t[i-1].fv) fer++;
        if (t[i].ov != t[i-1].inst[1]) ovm++;
      end
    end
    if (le >= 0 && ld > le)
      for (int i = le; i < ld; i++)
        if (t[i].fv != t[i+1].inst[16]) fer++;
    m = (obs.size() < exp.size()) ? obs.size() : exp.size();
    for (int k = 0; k < m; k++)
      if (obs[k] != exp[k]) seqe++;
    chk({p, "_seq_len"}, obs.size(), exp.size());
    chk({p, "_seq_words"}, seqe, 0);
    chk({p, "_handshake"}, hs, 0);
    chk({p, "_rdy_cycles"}, nr, lkw - 1);
    chk({p, "_drain_fifo"}, fer, 0);
    chk({p, "_invariants"}, inv, 0);
    chk({p, "_load_after_kwr"}, fl - lkw, 1);
    chk({p, "_load_span"}, ll - fl, kr - 1);
    chk({p, "_pad_gap"}, fe - ll, pd + 1);
    chk({p, "_exec_span"}, le - fe, qr - 1);
    chk({p, "_read_after_drain"}, fr - ld, 1);
    chk({p, "_read_span"}, lr - fr, qr - 1);
    chk({p, "_ov_timing"}, ovm, 0);
    chk({p, "_ov_count"}, nov, qr);
    chk({p, "_done_count"}, ndn, 1);
    chk({p, "_done_pos"}, di, lr + 1);
    chk({p, "_busy_cycles"}, nb, lr - 1);
    if (di >= 0 && di < n) begin
      chk({p, "_done_with_ov"}, t[di].ov, 1);
      chk({p, "_idle_at_done"}, t[di].bsy, 0);
    end
  endtask

  task automatic drive(input int mode, input int cyc);
    if (mode == 1) begin
      in_valid   = !(cyc >= 5 && cyc <= 7);
      fifo_valid = (cyc % 2 == 0);
      start_i    = 1'b0;
    end else begin
      if (mode == 0) begin
        in_valid   = 1'b1;
        fifo_valid = 1'b1;
      end else begin
        in_valid   = ($urandom_range(0, 3) != 0);
        fifo_valid = ($urandom_range(0, 1) == 1);
      end
      start_i = a_busy && b_busy && ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic run_pass(input int mode);
    bit da, db;
    int cyc;
    qa.delete();
    qb.delete();
    @(posedge clk); #1;
    rec = 1'b1;
    drive(mode, 0);
    start_i = 1'b1;
    da = 0; db = 0; cyc = 0;
    while (!(da && db) && cyc < 3000) begin
      @(negedge clk);
      if (a_done) da = 1;
      if (b_done) db = 1;
      @(posedge clk); #1;
      cyc++;
      drive(mode, cyc);
    end
    start_i  = 1'b0;
    in_valid = 1'b0;
    chk("pass_done_seen", {30'd0, da, db}, 32'd3);
    repeat (3) @(negedge clk);
    #1 rec = 1'b0;
    if (mode == 1 && qa.size() > 9) begin
      chk("A_stall_c6", qa[6].inst, 0);
      chk("A_stall_c7", qa[7].inst, 0);
      chk("A_stall_c8", qa[8].inst, 0);
      chk("A_resume_addr4", qa[9].inst, mk(0, 4));
    end
    check_trace(0);
    check_trace(1);
  endtask

  task automatic reset_mid_exec();
    bit seen;
    @(posedge clk); #1;
    start_i = 1'b1; in_valid = 1'b1; fifo_valid = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (a_inst[7]) seen = 1;
    end
    chk("rst_reach_exec", {31'd0, seen}, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_A_inst", a_inst, 0);
    chk("rst_A_busy", a_busy, 0);
    chk("rst_A_ov", a_ov, 0);
    chk("rst_A_rdy", a_rdy, 0);
    chk("rst_B_inst", b_inst, 0);
    chk("rst_B_busy", b_busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    start_i = 1'b0; in_valid = 1'b0;
    fifo_valid = 1'b0; rec = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("init_A_inst", a_inst, 0);
    chk("init_A_busy", a_busy, 0);
    chk("init_A_done", a_done, 0);
    chk("init_A_ov", a_ov, 0);
    chk("init_B_inst", b_inst, 0);
    chk("init_B_busy", b_busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_pass(0);
    run_pass(1);
    reset_mid_exec();
    run_pass(0);
    for (int r = 0; r < 3; r++) run_pass(2);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
